// File: rtl/even_counter.sv
// Free-running even-number counter: START, START+STEP, ... LAST, then wraps.
// Define ECOUNTER_DOWN_EN to count downward from LAST to START instead.
module even_counter #(
  parameter int WIDTH = 4,
  parameter int STEP  = 2,   // nonzero, divides (LAST - START)
  parameter int START = 0,
  parameter int LAST  = 14   // START < LAST < 2**WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH:0] START_W = (WIDTH+1)'(START);
  localparam logic [WIDTH:0] LAST_W  = (WIDTH+1)'(LAST);
  localparam logic [WIDTH:0] STEP_W  = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   offset;
  logic [WIDTH:0]   step_val;
  logic             in_range;
  logic             aligned;
  logic             valid;

  // A value is only trusted if it lies on the START + k*STEP lattice inside
  // [START, LAST]; anything else (e.g. an upset) restarts the sequence.
  always_comb begin
    cnt_ext  = {1'b0, cnt_reg};
    offset   = cnt_ext - START_W;
    in_range = (cnt_ext >= START_W) && (cnt_ext <= LAST_W);
    aligned  = (offset % STEP_W) == '0;
    valid    = in_range && aligned;
`ifdef ECOUNTER_DOWN_EN
    step_val = cnt_ext - STEP_W;
    // A borrow in the extended MSB can only come from a corrupt value.
    if (!valid || (cnt_ext == START_W) || step_val[WIDTH])
      cnt_next = LAST_W[WIDTH-1:0];
    else
      cnt_next = step_val[WIDTH-1:0];
`else
    step_val = cnt_ext + STEP_W;
    // The extra bit catches any carry out instead of letting it wrap.
    if (!valid || (cnt_ext == LAST_W) || (step_val > LAST_W))
      cnt_next = START_W[WIDTH-1:0];
    else
      cnt_next = step_val[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef ECOUNTER_DOWN_EN
      cnt_reg <= LAST_W[WIDTH-1:0];
`else
      cnt_reg <= START_W[WIDTH-1:0];
`endif
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: tb/tb_even_counter.sv
// Bench for even_counter: reset hold, vector table, async reset, upset recovery
// and a randomized run against a position-based sequence model.
`timescale 1ns/1ps
module tb_even_counter;

  localparam int WIDTH  = 4;
  localparam int STEP   = 2;
  localparam int START  = 0;
  localparam int LAST   = 14;
  localparam int PERIOD = (LAST - START) / STEP + 1;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             rst;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  even_counter #(
    .WIDTH(WIDTH), .STEP(STEP), .START(START), .LAST(LAST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  // Value at position pos of the sequence, counted from the reset value.
  function automatic logic [WIDTH-1:0] seq(int pos);
`ifdef ECOUNTER_DOWN_EN
    return WIDTH'(LAST - pos * STEP);
`else
    return WIDTH'(START + pos * STEP);
`endif
  endfunction

  task automatic check(string name, logic [WIDTH-1:0] got, logic [WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t cnt=%0d expected=%0d", name, $time, got, exp);
    end else begin
      $display("ok   %s t=%0t cnt=%0d", name, $time, got);
    end
  endtask

  initial begin
    int pos;
    int r;
    logic [WIDTH-1:0] upsets[3];

    // Release, wrap, a one-cycle synchronous reset, then resume.
    for (int i = 0; i < 9; i++) vecs[i] = '{1'b0, seq((i + 1) % PERIOD)};
    vecs[9]  = '{1'b1, seq(0)};
    vecs[10] = '{1'b0, seq(1)};
    vecs[11] = '{1'b0, seq(2)};

    // Reset hold across the 25 ns and 75 ns edges.
    reset = 1'b1;
    #10;
    check("reset_hold_0", cnt, seq(0));
    @(posedge clk); #1;
    check("reset_hold_25", cnt, seq(0));
    @(posedge clk); #1;
    check("reset_hold_75", cnt, seq(0));

    // Release at 100 ns then table of per-edge expectations.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), cnt, vecs[i].exp);
    end

    // Asynchronous reset between edges, mid-count.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_async", cnt, seq(3));
    #9 reset = 1'b1;
    #1;
    check("async_assert", cnt, seq(0));
    @(posedge clk); #1;
    check("async_held", cnt, seq(0));
    #9 reset = 1'b0;
    @(posedge clk); #1;
    check("async_release", cnt, seq(1));

    // Upset recovery: corrupt the register, expect a restart from the reset value.
    upsets[0] = 4'd7;
    upsets[1] = 4'd15;
    upsets[2] = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      force dut.cnt_reg = upsets[i];
      #1;
      release dut.cnt_reg;
      @(posedge clk); #1;
      check($sformatf("recover%0d", i), cnt, seq(0));
      @(posedge clk); #1;
      check($sformatf("recover%0d_next", i), cnt, seq(1));
    end

    // Randomized reset pattern against the position model.
    pos = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 15));
      reset = (r == 0);
      if (r == 1) begin
        #5 reset = 1'b1;
        #1;
        check("rand_pulse", cnt, seq(0));
        #5 reset = 1'b0;
        pos = 0;
      end
      @(posedge clk);
      if (reset) pos = 0;
      else pos = (pos + 1) % PERIOD;
      #1;
      check($sformatf("rand%0d", i), cnt, seq(pos));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
